pulse_width_decoder: RTL and testbench

- Observes the single-bit idle/busy timing line driven by the team's parametrized trigger counter and decodes each busy pulse back into the multiplier that produced it.
- The line idles high; a busy pulse is low for nominally TVALUE·2^m cycles, m ∈ {0..3}.
- The block measures each low phase and reports the decoded multiplier, the measured length and a pass/fail verdict.
- It also flags malformed or overlong pulses.
- It sits at the receiving end of the timing line, in the same clock domain as the counter.

---
 rtl/pulse_width_decoder_if.sv | 31 +++
 rtl/pulse_width_decoder.sv | 151 +++++++++++++++
 tb/tb_pulse_width_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pulse_width_decoder_if.sv
// Timing-line bundle between the trigger counter side and the decoder.
// The slave modport is the decoder's view; master is the line driver/observer.
interface pulse_width_decoder_if;
    logic        cf_in;
    logic        busy;
    logic        valid;
    logic        err;
    logic [1:0]  mult;
    logic [31:0] len;
    logic [15:0] pulse_cnt;

    modport master (
        output cf_in,
        input  busy,
        input  valid,
        input  err,
        input  mult,
        input  len,
        input  pulse_cnt
    );

    modport slave (
        input  cf_in,
        output busy,
        output valid,
        output err,
        output mult,
        output len,
        output pulse_cnt
    );
endinterface

// File: rtl/pulse_width_decoder.sv
// Measures each low phase of the idle-high timing line and decodes its length
// back into the multiplier m (length ~ TVALUE*2^m), flagging bad or overlong
// pulses. All outputs are registered.
module pulse_width_decoder #(
    parameter int unsigned TVALUE = 7,
    parameter int unsigned TOL    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    pulse_width_decoder_if.slave    bus
);

    localparam logic [31:0] TOL_W = 32'(TOL);
    localparam logic [31:0] NOM0  = 32'(TVALUE);
    localparam logic [31:0] NOM1  = 32'(TVALUE * 2);
    localparam logic [31:0] NOM2  = 32'(TVALUE * 4);
    localparam logic [31:0] NOM3  = 32'(TVALUE * 8);
    localparam logic [31:0] LMAX  = 32'(TVALUE * 8 + TOL);

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        IDLE    = 2'd1,
        MEASURE = 2'd2,
        OVERRUN = 2'd3
    } state_t;

    // Window test written so the unsigned compare never underflows.
    function automatic logic in_win(input logic [31:0] l, input logic [31:0] n);
        return ((l + TOL_W) >= n) && (l <= (n + TOL_W));
    endfunction

    // Returns {hit, m} for the smallest matching multiplier.
    function automatic logic [2:0] decode(input logic [31:0] l);
        logic [2:0] r;
        if (in_win(l, NOM0)) begin
            r = 3'b100;
        end else if (in_win(l, NOM1)) begin
            r = 3'b101;
        end else if (in_win(l, NOM2)) begin
            r = 3'b110;
        end else if (in_win(l, NOM3)) begin
            r = 3'b111;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    state_t      state_r, state_s;
    logic [31:0] cnt_r, cnt_s;
    logic        busy_r, busy_s;
    logic        valid_r, valid_s;
    logic        err_r, err_s;
    logic [1:0]  mult_r, mult_s;
    logic [31:0] len_r, len_s;
    logic [15:0] pulse_cnt_r, pulse_cnt_s;
    logic [2:0]  dec_s;

    // State register and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ARM;
            cnt_r       <= 32'd0;
            busy_r      <= 1'b0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
            mult_r      <= 2'd0;
            len_r       <= 32'd0;
            pulse_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            valid_r     <= valid_s;
            err_r       <= err_s;
            mult_r      <= mult_s;
            len_r       <= len_s;
            pulse_cnt_r <= pulse_cnt_s;
        end
    end

    // Next-state, low-phase counting and decode of a finished pulse.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        valid_s     = 1'b0;
        err_s       = 1'b0;
        mult_s      = mult_r;
        len_s       = len_r;
        pulse_cnt_s = pulse_cnt_r;
        dec_s       = decode(cnt_r);
        case (state_r)
            ARM: begin
                // A low phase already in progress is skipped entirely.
                if (bus.cf_in) begin
                    state_s = IDLE;
                end else begin
                    state_s = ARM;
                end
            end
            IDLE: begin
                if (!bus.cf_in) begin
                    state_s = MEASURE;
                    cnt_s   = 32'd1;
                end else begin
                    state_s = IDLE;
                end
            end
            MEASURE: begin
                if (!bus.cf_in) begin
                    if (cnt_r < LMAX) begin
                        cnt_s = cnt_r + 32'd1;
                    end else begin
                        state_s = OVERRUN;
                        err_s   = 1'b1;
                        len_s   = LMAX + 32'd1;
                    end
                end else begin
                    state_s = IDLE;
                    len_s   = cnt_r;
                    if (dec_s[2]) begin
                        valid_s     = 1'b1;
                        mult_s      = dec_s[1:0];
                        pulse_cnt_s = pulse_cnt_r + 16'd1;
                    end else begin
                        err_s = 1'b1;
                    end
                end
            end
            OVERRUN: begin
                if (bus.cf_in) begin
                    state_s = IDLE;
                end else begin
                    state_s = OVERRUN;
                end
            end
            default: begin
                state_s = ARM;
            end
        endcase
        busy_s = (state_s == MEASURE);
    end

    assign bus.busy      = busy_r;
    assign bus.valid     = valid_r;
    assign bus.err       = err_r;
    assign bus.mult      = mult_r;
    assign bus.len       = len_r;
    assign bus.pulse_cnt = pulse_cnt_r;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed bench for pulse_width_decoder with default TVALUE=7, TOL=1
// (nominals 7/14/28/56, LMAX=57).
module tb_pulse_width_decoder;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    pulse_width_decoder_if bus_if ();

    pulse_width_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          low;
        logic        exp_valid;
        logic [1:0]  exp_mult;
        logic [31:0] exp_len;
        logic [15:0] exp_pcnt;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Drive one sample, let the edge take it, then settle for observation.
    task automatic step(input logic v);
        bus_if.cf_in = v;
        @(posedge clk);
        #1;
    endtask

    // Count cycles where outputs are not quiet (busy low, no valid/err).
    task automatic quiet_steps(input logic v, input int n, inout int bad);
        for (int i = 0; i < n; i++) begin
            step(v);
            if (bus_if.busy !== 1'b0 || bus_if.valid !== 1'b0 || bus_if.err !== 1'b0) bad++;
        end
    endtask

    task automatic low_steps(input int n, inout int bad);
        for (int i = 0; i < n; i++) begin
            step(1'b0);
            if (bus_if.busy !== 1'b1 || bus_if.valid !== 1'b0 || bus_if.err !== 1'b0) bad++;
        end
    endtask

    task automatic check_end(input string tag, input logic ev, input logic ee,
                             input logic [1:0] em, input logic [31:0] el, input logic [15:0] ep);
        check({tag, "_valid"}, 32'(bus_if.valid), 32'(ev));
        check({tag, "_err"},   32'(bus_if.err),   32'(ee));
        check({tag, "_mult"},  32'(bus_if.mult),  32'(em));
        check({tag, "_len"},   bus_if.len,        el);
        check({tag, "_pcnt"},  32'(bus_if.pulse_cnt), 32'(ep));
        check({tag, "_busy"},  32'(bus_if.busy),  32'd0);
    endtask

    initial begin
        int bad;
        checks   = 0;
        failures = 0;

        vecs[0]  = '{7,  1'b1, 2'd0, 32'd7,  16'd1};
        vecs[1]  = '{14, 1'b1, 2'd1, 32'd14, 16'd2};
        vecs[2]  = '{28, 1'b1, 2'd2, 32'd28, 16'd3};
        vecs[3]  = '{56, 1'b1, 2'd3, 32'd56, 16'd4};
        vecs[4]  = '{6,  1'b1, 2'd0, 32'd6,  16'd5};
        vecs[5]  = '{8,  1'b1, 2'd0, 32'd8,  16'd6};
        vecs[6]  = '{13, 1'b1, 2'd1, 32'd13, 16'd7};
        vecs[7]  = '{15, 1'b1, 2'd1, 32'd15, 16'd8};
        vecs[8]  = '{5,  1'b0, 2'd1, 32'd5,  16'd8};
        vecs[9]  = '{9,  1'b0, 2'd1, 32'd9,  16'd8};
        vecs[10] = '{20, 1'b0, 2'd1, 32'd20, 16'd8};
        vecs[11] = '{1,  1'b0, 2'd1, 32'd1,  16'd8};
        vecs[12] = '{57, 1'b1, 2'd3, 32'd57, 16'd9};

        // Reset held with the line low, then a low tail that must be ignored.
        reset = 1'b1;
        bus_if.cf_in = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        check_end("reset", 1'b0, 1'b0, 2'd0, 32'd0, 16'd0);
        reset = 1'b0;
        bad = 0;
        quiet_steps(1'b0, 10, bad);
        quiet_steps(1'b1, 3, bad);
        check("arm_quiet", 32'(bad), 32'd0);
        check_end("arm_end", 1'b0, 1'b0, 2'd0, 32'd0, 16'd0);

        // Table of single pulses, each followed by three high samples.
        foreach (vecs[k]) begin
            bad = 0;
            low_steps(vecs[k].low, bad);
            check($sformatf("v%0d_low", k), 32'(bad), 32'd0);
            step(1'b1);
            check_end($sformatf("v%0d", k), vecs[k].exp_valid, !vecs[k].exp_valid,
                      vecs[k].exp_mult, vecs[k].exp_len, vecs[k].exp_pcnt);
            bad = 0;
            quiet_steps(1'b1, 2, bad);
            check($sformatf("v%0d_tail", k), 32'(bad), 32'd0);
        end

        // Overrun: err once at the 58th low sample, nothing on release.
        bad = 0;
        low_steps(57, bad);
        check("ovr_low", 32'(bad), 32'd0);
        step(1'b0);
        check_end("ovr", 1'b0, 1'b1, 2'd3, 32'd58, 16'd9);
        bad = 0;
        quiet_steps(1'b0, 12, bad);
        quiet_steps(1'b1, 3, bad);
        check("ovr_tail", 32'(bad), 32'd0);
        check_end("ovr_end", 1'b0, 1'b0, 2'd3, 32'd58, 16'd9);

        // Back-to-back 14 / 1 high / 28.
        bad = 0;
        low_steps(14, bad);
        step(1'b1);
        check_end("b2b_a", 1'b1, 1'b0, 2'd1, 32'd14, 16'd10);
        low_steps(28, bad);
        check("b2b_low", 32'(bad), 32'd0);
        step(1'b1);
        check_end("b2b_b", 1'b1, 1'b0, 2'd2, 32'd28, 16'd11);
        bad = 0;
        quiet_steps(1'b1, 2, bad);
        check("b2b_tail", 32'(bad), 32'd0);

        // Reset at cnt=10 of a 28-cycle pulse, released while still low.
        bad = 0;
        low_steps(10, bad);
        check("rst_pre", 32'(bad), 32'd0);
        reset = 1'b1;
        step(1'b0);
        check_end("rst_mid", 1'b0, 1'b0, 2'd0, 32'd0, 16'd0);
        reset = 1'b0;
        bad = 0;
        quiet_steps(1'b0, 17, bad);
        quiet_steps(1'b1, 3, bad);
        check("rst_ignored", 32'(bad), 32'd0);
        check_end("rst_quiet", 1'b0, 1'b0, 2'd0, 32'd0, 16'd0);
        bad = 0;
        low_steps(7, bad);
        check("rst_next_low", 32'(bad), 32'd0);
        step(1'b1);
        check_end("rst_next", 1'b1, 1'b0, 2'd0, 32'd7, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
